dii_packet_arbiter: RTL and testbench

//   Shares one DII output channel among N DII input channels.
//   - Arbitration is round-robin at packet granularity: a granted input keeps
//     the output until its flit with last=1 is transferred.
//   - A 2-entry output FIFO gives full throughput and registered outputs.
//   - Sits between several debug modules and one shared link or router port.
//

---
 rtl/dii_packet_arbiter.sv | 164 ++++++++++++++++
 tb/tb_dii_packet_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dii_packet_arbiter.sv
// Packet-granular round-robin arbiter merging N DII input channels onto one
// output through a 2-entry registered FIFO.

module dii_packet_arbiter_lane (
   input  logic        sel,
   input  logic        locked,
   input  logic        space,
   input  logic        in_valid,
   input  logic        in_last,
   input  logic [15:0] in_data,
   output logic        in_ready,
   output logic        xfer,
   output logic [16:0] word
);
   assign in_ready = sel & locked & space;
   assign xfer     = in_ready & in_valid;
   // Masked so the top can OR all lanes into the granted flit.
   assign word     = sel ? {in_last, in_data} : 17'd0;
endmodule

module dii_packet_arbiter #(
   parameter int N     = 1,
   parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N*16-1:0]   in_data,
   input  logic [N-1:0]      in_last,
   input  logic [N-1:0]      in_valid,
   output logic [N-1:0]      in_ready,
   output logic [15:0]       out_data,
   output logic              out_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PTR_W-1:0]  grant,
   output logic              busy
);
   typedef enum logic {IDLE, LOCKED} state_t;

   state_t           state_q, state_d;
   logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0] grant_q, grant_d;
   logic             busy_q, busy_d;
   logic [1:0]       cnt_q, cnt_d;
   logic [16:0]      head_q, head_d;
   logic [16:0]      tail_q, tail_d;

   logic             locked, space, enq, deq;
   logic [16:0]      enq_word;
   logic [PTR_W-1:0] sel_idx;
   logic [N-1:0]     lane_xfer;
   logic [16:0]      lane_word [N];

   assign locked = (state_q == LOCKED);
   // Full FIFO can still accept when the head leaves in the same cycle.
   assign space  = (cnt_q != 2'd2) | out_ready;
   assign deq    = (cnt_q != 2'd0) & out_ready;
   assign enq    = |lane_xfer;

   for (genvar i = 0; i < N; i++) begin : g_lane
      dii_packet_arbiter_lane u_lane (
         .sel      (grant_q == PTR_W'(i)),
         .locked   (locked),
         .space    (space),
         .in_valid (in_valid[i]),
         .in_last  (in_last[i]),
         .in_data  (in_data[16*i +: 16]),
         .in_ready (in_ready[i]),
         .xfer     (lane_xfer[i]),
         .word     (lane_word[i])
      );
   end

   always_comb begin
      enq_word = 17'd0;
      for (int i = 0; i < N; i++) enq_word = enq_word | lane_word[i];
   end

   // Scan downward so the closest requester after rr_ptr wins.
   always_comb begin
      int idx;
      sel_idx = rr_ptr_q;
      idx     = 0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = (int'(rr_ptr_q) + k) % N;
         if (in_valid[idx]) sel_idx = PTR_W'(idx);
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      grant_d  = grant_q;
      busy_d   = busy_q;
      case (state_q)
         IDLE: begin
            if (|in_valid) begin
               state_d = LOCKED;
               grant_d = sel_idx;
               busy_d  = 1'b1;
            end
         end
         LOCKED: begin
            if (enq && enq_word[16]) begin
               state_d  = IDLE;
               busy_d   = 1'b0;
               rr_ptr_d = (grant_q == PTR_W'(N - 1)) ? '0 : grant_q + PTR_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d  = cnt_q;
      head_d = head_q;
      tail_d = tail_q;
      case ({enq, deq})
         2'b10: begin
            if (cnt_q == 2'd0) head_d = enq_word;
            else               tail_d = enq_word;
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            head_d = tail_q;
            cnt_d  = cnt_q - 2'd1;
         end
         2'b11: begin
            if (cnt_q == 2'd1) head_d = enq_word;
            else begin
               head_d = tail_q;
               tail_d = enq_word;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         busy_q   <= 1'b0;
         cnt_q    <= 2'd0;
         head_q   <= 17'd0;
         tail_q   <= 17'd0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         busy_q   <= busy_d;
         cnt_q    <= cnt_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
      end
   end

   assign out_valid = (cnt_q != 2'd0);
   assign out_data  = head_q[15:0];
   assign out_last  = head_q[16];
   assign grant     = grant_q;
   assign busy      = busy_q;
endmodule

// File: tb/tb_dii_packet_arbiter.sv
// Randomized plus directed bench for dii_packet_arbiter (N=4) against a
// packet-level reference model of arbitration and the output FIFO.

module tb_dii_packet_arbiter;
   localparam int N = 4;
   localparam int PTR_W = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N*16-1:0]   in_data;
   logic [N-1:0]      in_last, in_valid, in_ready;
   logic [15:0]       out_data;
   logic              out_last, out_valid, out_ready;
   logic [PTR_W-1:0]  grant;
   logic              busy;

   always #5 clk = ~clk;

   dii_packet_arbiter #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_last(in_last),
      .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
      .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
      .grant(grant), .busy(busy)
   );

   int total = 0, bad = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // reference model state
   logic [16:0] mq[$];
   bit          m_locked;
   int          m_grant, m_rr;
   logic [16:0] src [N][$];
   bit          cur_v [N];
   int          rdy_mode, gap_mode, cyc, acc_cnt;
   logic [16:0] olog[$];
   int          ocyc[$];
   int          acyc[$];
   logic [N-1:0] exp_rdy;
   logic [16:0] w_m;

   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mq.delete(); m_locked = 0; m_grant = 0; m_rr = 0;
            for (int i = 0; i < N; i++) cur_v[i] = 0;
            in_valid = '0;
            cyc++;
            continue;
         end
         for (int i = 0; i < N; i++) begin
            if (!cur_v[i] && src[i].size() > 0)
               cur_v[i] = gap_mode != 0 ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_valid[i] = cur_v[i];
            if (cur_v[i]) begin
               in_data[16*i +: 16] = src[i][0][15:0];
               in_last[i] = src[i][0][16];
            end else begin
               in_data[16*i +: 16] = 16'($urandom);
               in_last[i] = 1'($urandom);
            end
         end
         out_ready = rdy_mode == 0 ? 1'b0 : rdy_mode == 1 ? 1'b1 : 1'($urandom_range(0, 1));
         #1;
         exp_rdy = '0;
         if (m_locked && (mq.size() < 2 || out_ready)) exp_rdy[m_grant] = 1'b1;
         chk("busy", busy, m_locked);
         chk("grant", grant, m_grant);
         chk("in_ready", in_ready, exp_rdy);
         chk("out_valid", out_valid, mq.size() != 0);
         if (mq.size() != 0) chk("out_flit", {out_last, out_data}, mq[0]);
         if (mq.size() != 0 && out_ready) begin
            olog.push_back(mq.pop_front());
            ocyc.push_back(cyc);
         end
         if (m_locked) begin
            if (exp_rdy[m_grant] && in_valid[m_grant]) begin
               w_m = src[m_grant].pop_front();
               mq.push_back(w_m);
               cur_v[m_grant] = 0;
               acc_cnt++;
               acyc.push_back(cyc);
               if (w_m[16]) begin
                  m_locked = 0;
                  m_rr = (m_grant + 1) % N;
               end
            end
         end else if (in_valid != 0) begin
            int sel;
            sel = -1;
            for (int k = 0; k < N; k++) begin
               int idx;
               idx = (m_rr + k) % N;
               if (sel < 0 && in_valid[idx]) sel = idx;
            end
            m_locked = 1;
            m_grant = sel;
         end
         cyc++;
      end
   end

   task automatic ld(int i, int n, logic [15:0] base);
      logic [16:0] w;
      for (int k = 0; k < n; k++) begin
         w = {(k == n - 1), base + 16'(k)};
         src[i].push_back(w);
      end
   endtask

   task automatic wait_log(int n);
      int b;
      b = 0;
      while (olog.size() < n && b < 200) begin
         @(posedge clk);
         b++;
      end
      chk("wait_log", olog.size() >= n, 1);
   endtask

   task automatic clr();
      olog.delete(); ocyc.delete(); acyc.delete(); acc_cnt = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [16:0] expv [$];
      int b;
      rst_n = 1'b0; in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b0;
      rdy_mode = 1; gap_mode = 0; cyc = 0; acc_cnt = 0;
      m_locked = 0; m_grant = 0; m_rr = 0;
      for (int i = 0; i < N; i++) cur_v[i] = 0;
      #2;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_flit", {out_last, out_data}, 0);
      chk("rst_grant", grant, 0);
      chk("rst_busy", busy, 0);
      #21 rst_n = 1'b1;

      // idle after reset
      repeat (10) @(posedge clk);
      #2;
      chk("idle_in_ready", in_ready, 0);
      chk("idle_out_valid", out_valid, 0);
      chk("idle_busy", busy, 0);

      // all four inputs request at once
      clr();
      @(posedge clk);
      for (int i = 0; i < N; i++) ld(i, 3, 16'(i * 16'h1000 + 1));
      wait_log(12);
      for (int k = 0; k < 12; k++)
         chk("rr_order", olog[k], {(k % 3 == 2), 16'((k / 3) * 16'h1000 + (k % 3) + 1)});
      chk("rr_span", ocyc[11] - ocyc[0], 14);

      // rr_ptr=2 after input 1: input 3 beats input 0
      clr();
      @(posedge clk);
      ld(1, 1, 16'h1001);
      wait_log(1);
      @(posedge clk);
      ld(0, 1, 16'h0001);
      ld(3, 1, 16'h3001);
      wait_log(3);
      chk("rr_skip0", olog[0], 17'h11001);
      chk("rr_skip1", olog[1], 17'h13001);
      chk("rr_skip2", olog[2], 17'h10001);

      // backpressure: FIFO fills to 2 then stalls
      clr();
      rdy_mode = 0;
      @(posedge clk);
      ld(1, 5, 16'h1001);
      repeat (10) @(posedge clk);
      #2;
      chk("bp_accepted", acc_cnt, 2);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      rdy_mode = 1;
      wait_log(5);
      for (int k = 0; k < 5; k++) chk("bp_data", olog[k], {(k == 4), 16'(16'h1001 + k)});
      for (int k = 0; k < 4; k++) chk("bp_stream", ocyc[k + 1] - ocyc[k], 1);

      // single-flit packets back-to-back from input 2
      clr();
      @(posedge clk);
      for (int k = 0; k < 4; k++) ld(2, 1, 16'(16'h2001 + k));
      wait_log(4);
      for (int k = 0; k < 3; k++) chk("single_gap", acyc[k + 1] - acyc[k], 2);
      chk("single_rr", m_rr, 3);

      // mid-packet reset with a full FIFO
      clr();
      rdy_mode = 0;
      @(posedge clk);
      ld(3, 5, 16'h3001);
      b = 0;
      while (acc_cnt < 2 && b < 50) begin @(posedge clk); b++; end
      chk("mid_fill", acc_cnt, 2);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      for (int i = 0; i < N; i++) src[i].delete();
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      rdy_mode = 1;
      clr();
      @(posedge clk);
      ld(3, 1, 16'h3001);
      ld(0, 1, 16'h0001);
      wait_log(2);
      chk("post_rst0", olog[0], 17'h10001);
      chk("post_rst1", olog[1], 17'h13001);

      // randomized traffic with random gaps and backpressure
      clr();
      gap_mode = 1; rdy_mode = 2;
      repeat (3000) begin
         @(posedge clk);
         for (int i = 0; i < N; i++)
            if (src[i].size() == 0 && $urandom_range(0, 7) == 0) begin
               int len;
               logic [16:0] w;
               len = $urandom_range(1, 5);
               for (int k = 0; k < len; k++) begin
                  w = {(k == len - 1), 4'(i), 12'($urandom)};
                  src[i].push_back(w);
               end
            end
      end
      gap_mode = 0; rdy_mode = 1;
      b = 0;
      while (b < 500 && (mq.size() != 0 || m_locked ||
             src[0].size() + src[1].size() + src[2].size() + src[3].size() != 0)) begin
         @(posedge clk);
         b++;
      end
      chk("drain", (mq.size() == 0) && !m_locked, 1);
      chk("rand_flow", olog.size(), acc_cnt);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
